// File: rtl/buffer_reader_pkg.sv
// Shared definitions for the buffer reader: FSM state encoding and default widths.
`timescale 1ns/1ps
package buffer_reader_pkg;

  localparam int unsigned DEF_DWIDTH = 16;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } reader_state_t;

endpackage

// File: rtl/buffer_reader.sv
// Pops a fixed-length burst from a show-ahead FIFO and presents it as a
// valid/ready stream through a single output register stage.
`timescale 1ns/1ps
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  reader_state_t    state_q;
  reader_state_t    state_d;
  logic [LEN_W-1:0] cnt_q;
  logic             pop;
  logic             beat_acc;
  logic             launch;
  logic             kill;

  // Pop when streaming, words remain, FIFO has data and the output slot is free.
  always_comb begin
    pop      = (state_q == STREAM) && (cnt_q != '0) && !fifo_empty && (!m_valid || m_ready);
    beat_acc = m_valid && m_ready;
    launch   = (state_q == IDLE) && start && !abort;
    kill     = abort && (state_q != IDLE);
  end

  assign fifo_rd_en = pop;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides completion of the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = (len != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat_acc && m_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word counter and output register stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (kill) begin
      cnt_q   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (launch && (len != '0)) begin
        cnt_q <= len;
      end
      if (pop) begin
        m_data  <= fifo_dout;
        m_valid <= 1'b1;
        m_last  <= (cnt_q == LEN_W'(1));
        cnt_q   <= cnt_q - LEN_W'(1);
      end else if (beat_acc) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

  // Status flags registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == STREAM);
      done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader with a behavioural show-ahead FIFO.
`timescale 1ns/1ps
module tb_buffer_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [LW-1:0] len;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model
  logic [DW-1:0] fmem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_clr;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = fmem[rd_ptr[5:0]];

  // Monitors
  int            rd_n   = 0;
  int            mv_n   = 0;
  int            done_n = 0;
  int            rx_n   = 0;
  logic [DW-1:0] rx_data [0:63];
  logic          rx_last [0:63];

  buffer_reader #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .len        (len),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    if (fifo_rd_en) rd_n <= rd_n + 1;
    if (m_valid) mv_n <= mv_n + 1;
    if (done) done_n <= done_n + 1;
    if (m_valid && m_ready) begin
      rx_data[rx_n[5:0]] <= m_data;
      rx_last[rx_n[5:0]] <= m_last;
      rx_n <= rx_n + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input logic [DW-1:0] w);
    fmem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush();
    @(negedge clk); fifo_clr = 1'b1;
    @(negedge clk); fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || fifo_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h b=%b dn=%b rd=%b want all 0", m_valid, m_last, m_data, busy, done, fifo_rd_en);
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got busy=%b done=%b v=%b want 0 0 0", busy, done, m_valid);
    end
  endtask

  task automatic test_basic();
    int b_rd;
    b_rd = rd_n;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    m_ready = 1'b1;
    @(negedge clk); start = 1'b1; len = 8'd4;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || fifo_rd_en !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_first_pop: got busy=%b rd=%b v=%b want 1 1 0", busy, fifo_rd_en, m_valid);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== DW'(k) || m_last !== (k == 4)) begin
        n_err++;
        $display("FAIL basic_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, m_valid, m_data, m_last, DW'(k), (k == 4));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got done=%b v=%b busy=%b want 1 0 0", done, m_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || (rd_n - b_rd) != 4) begin
      n_err++;
      $display("FAIL basic_tail: got done=%b pops=%0d want done=0 pops=4", done, rd_n - b_rd);
    end
  endtask

  task automatic test_stall();
    int b_rd, b_rx, b_done;
    logic pv, pr;
    logic [DW-1:0] pd;
    b_rd = rd_n; b_rx = rx_n; b_done = done_n;
    push(16'h0011); push(16'h0022); push(16'h0033);
    m_ready = 1'b0;
    @(negedge clk); start = 1'b1; len = 8'd3;
    @(negedge clk); start = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    for (int i = 0; i < 40; i++) begin
      if (pv && !pr) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== pd) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", m_valid, m_data, pd);
        end
      end
      if (done_n != b_done) break;
      m_ready = ((i % 3) == 0);
      pv = m_valid; pr = m_ready; pd = m_data;
      @(negedge clk);
    end
    m_ready = 1'b1;
    n_cmp++;
    if ((done_n - b_done) != 1 || (rd_n - b_rd) != 3 || (rx_n - b_rx) != 3) begin
      n_err++;
      $display("FAIL stall_counts: got done=%0d pops=%0d beats=%0d want 1 3 3", done_n - b_done, rd_n - b_rd, rx_n - b_rx);
    end
    n_cmp++;
    if (rx_data[6'(b_rx)] !== 16'h0011 || rx_data[6'(b_rx + 1)] !== 16'h0022 || rx_data[6'(b_rx + 2)] !== 16'h0033 ||
        rx_last[6'(b_rx + 1)] !== 1'b0 || rx_last[6'(b_rx + 2)] !== 1'b1) begin
      n_err++;
      $display("FAIL stall_data: got %h %h %h last=%b want 0011 0022 0033 last=1",
               rx_data[6'(b_rx)], rx_data[6'(b_rx + 1)], rx_data[6'(b_rx + 2)], rx_last[6'(b_rx + 2)]);
    end
    @(negedge clk);
  endtask

  task automatic test_empty();
    int b_rd, b_rx, b_done;
    b_rd = rd_n; b_rx = rx_n; b_done = done_n;
    push(16'h00A1); push(16'h00A2);
    m_ready = 1'b1;
    @(negedge clk); start = 1'b1; len = 8'd5;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || (rx_n - b_rx) != 2) begin
      n_err++;
      $display("FAIL empty_pause: got busy=%b v=%b rd=%b beats=%0d want 1 0 0 2", busy, m_valid, fifo_rd_en, rx_n - b_rx);
    end
    push(16'h00A3); push(16'h00A4); push(16'h00A5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_n != b_done) break;
    end
    @(negedge clk);
    n_cmp++;
    if ((done_n - b_done) != 1 || (rd_n - b_rd) != 5 || (rx_n - b_rx) != 5) begin
      n_err++;
      $display("FAIL empty_counts: got done=%0d pops=%0d beats=%0d want 1 5 5", done_n - b_done, rd_n - b_rd, rx_n - b_rx);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (rx_data[6'(b_rx + k)] !== DW'(16'h00A1 + k) || rx_last[6'(b_rx + k)] !== (k == 4)) begin
        n_err++;
        $display("FAIL empty_word%0d: got d=%h l=%b want d=%h l=%b", k, rx_data[6'(b_rx + k)], rx_last[6'(b_rx + k)], DW'(16'h00A1 + k), (k == 4));
      end
    end
  endtask

  task automatic test_zero();
    int b_rd, b_mv, b_done;
    b_rd = rd_n; b_mv = mv_n; b_done = done_n;
    @(negedge clk); start = 1'b1; len = 8'd0;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: got done=%b busy=%b rd=%b v=%b want 1 0 0 0", done, busy, fifo_rd_en, m_valid);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || (rd_n - b_rd) != 0 || (mv_n - b_mv) != 0 || (done_n - b_done) != 1) begin
      n_err++;
      $display("FAIL zero_counts: got done=%b pops=%0d valids=%0d dones=%0d want 0 0 0 1", done, rd_n - b_rd, mv_n - b_mv, done_n - b_done);
    end
  endtask

  task automatic test_abort();
    int b_rd, b_rx, b_done;
    b_rd = rd_n; b_rx = rx_n; b_done = done_n;
    for (int i = 0; i < 6; i++) push(DW'(16'h00B1 + i));
    m_ready = 1'b1;
    @(negedge clk); start = 1'b1; len = 8'd6;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((rx_n - b_rx) >= 2) break;
      @(negedge clk);
    end
    n_cmp++;
    if ((rx_n - b_rx) != 2 || m_valid !== 1'b1 || m_data !== 16'h00B3) begin
      n_err++;
      $display("FAIL abort_setup: got beats=%0d v=%b d=%h want 2 1 00b3", rx_n - b_rx, m_valid, m_data);
    end
    abort = 1'b1; m_ready = 1'b0;
    @(negedge clk); abort = 1'b0; m_ready = 1'b1;
    n_cmp++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_clear: got v=%b l=%b busy=%b done=%b want 0 0 0 0", m_valid, m_last, busy, done);
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    n_cmp++;
    if ((done_n - b_done) != 0 || (rx_n - b_rx) != 2 || (wr_ptr - rd_ptr) != 3 || (rd_n - b_rd) != 3) begin
      n_err++;
      $display("FAIL abort_after: got dones=%0d beats=%0d level=%0d pops=%0d want 0 2 3 3", done_n - b_done, rx_n - b_rx, wr_ptr - rd_ptr, rd_n - b_rd);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    int b_rd, b_rx, b_done;
    b_rd = rd_n; b_rx = rx_n; b_done = done_n;
    for (int i = 0; i < 4; i++) push(DW'(16'h00C1 + i));
    m_ready = 1'b1;
    @(negedge clk); start = 1'b1; len = 8'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || fifo_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got v=%b l=%b d=%h b=%b dn=%b rd=%b want all 0", m_valid, m_last, m_data, busy, done, fifo_rd_en);
    end
    @(negedge clk); rstn = 1'b1;
    flush();
    push(16'h00D1); push(16'h00D2);
    @(negedge clk); start = 1'b1; len = 8'd2;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_n != b_done) break;
    end
    @(negedge clk);
    n_cmp++;
    if ((done_n - b_done) != 1 || (rx_n - b_rx) != 2 || (rd_n - b_rd) != 3) begin
      n_err++;
      $display("FAIL midreset_counts: got dones=%0d beats=%0d pops=%0d want 1 2 3", done_n - b_done, rx_n - b_rx, rd_n - b_rd);
    end
    n_cmp++;
    if (rx_data[6'(b_rx)] !== 16'h00D1 || rx_data[6'(b_rx + 1)] !== 16'h00D2 ||
        rx_last[6'(b_rx)] !== 1'b0 || rx_last[6'(b_rx + 1)] !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_data: got %h/%b %h/%b want 00d1/0 00d2/1",
               rx_data[6'(b_rx)], rx_last[6'(b_rx)], rx_data[6'(b_rx + 1)], rx_last[6'(b_rx + 1)]);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    len      = '0;
    m_ready  = 1'b0;
    fifo_clr = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_zero();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
